// File: rtl/hpdmc_fmlarb.sv
// hpdmc_fmlarb: 4-way arbiter sharing one FML 4x64 port between bus masters.
// Define HPDMC_FMLARB_FIXEDPRIO_EN for fixed priority (master 0 highest); default is round-robin.
module hpdmc_fmlarb #(
    parameter int sdram_depth = 26
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [4*sdram_depth-1:0] m_adr,
    input  logic [3:0]               m_stb,
    input  logic [3:0]               m_we,
    input  logic [31:0]              m_sel,
    input  logic [255:0]             m_di,
    output logic [3:0]               m_ack,
    output logic [63:0]              m_do,
    output logic [sdram_depth-1:0]   s_adr,
    output logic                     s_stb,
    output logic                     s_we,
    input  logic                     s_ack,
    output logic [7:0]               s_sel,
    output logic [63:0]              s_di,
    input  logic [63:0]              s_do
);

    typedef enum logic [1:0] {IDLE, REQ, WBURST} state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_q, last_d;
    logic [1:0] beat_q, beat_d;
    logic [1:0] winner;
    logic       xfer;

`ifdef HPDMC_FMLARB_FIXEDPRIO_EN
    always_comb begin
        winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m_stb[k]) winner = 2'(k);
        end
    end
`else
    logic [1:0] rr_idx;
    logic       found;

    // Search starts just after the last master served, wrapping mod 4.
    always_comb begin
        winner = last_q + 2'd1;
        rr_idx = '0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = last_q + 2'(k);
            if (!found && m_stb[rr_idx]) begin
                winner = rr_idx;
                found  = 1'b1;
            end
        end
    end
`endif

    // Data path always follows the granted master so write beats need no extra muxing.
    assign s_adr = m_adr[int'(grant_q)*sdram_depth +: sdram_depth];
    assign s_we  = m_we[grant_q];
    assign s_sel = m_sel[int'(grant_q)*8 +: 8];
    assign s_di  = m_di[int'(grant_q)*64 +: 64];
    assign m_do  = s_do;

    assign s_stb = (state_q == REQ) && m_stb[grant_q];
    assign xfer  = s_stb && s_ack;
    assign m_ack = xfer ? (4'b0001 << grant_q) : 4'b0000;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (|m_stb) begin
                    grant_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (xfer) begin
                    last_d = grant_q;
                    if (s_we) begin
                        state_d = WBURST;
                        beat_d  = 2'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!m_stb[grant_q]) begin
                    // Master withdrew its request without an ack.
                    state_d = IDLE;
                end
            end
            WBURST: begin
                if (beat_q == 2'd3) begin
                    beat_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hpdmc_fmlarb.sv
// Self-checking bench for hpdmc_fmlarb: vector table for first-grant arbitration
// plus hand-written sequences for ordering, write bursts, withdrawn requests and reset.
module tb_hpdmc_fmlarb;

    localparam int D = 26;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n;
    logic [4*D-1:0] m_adr;
    logic [3:0]     m_stb;
    logic [3:0]     m_we;
    logic [31:0]    m_sel;
    logic [255:0]   m_di;
    logic [3:0]     m_ack;
    logic [63:0]    m_do;
    logic [D-1:0]   s_adr;
    logic           s_stb;
    logic           s_we;
    logic           s_ack;
    logic [7:0]     s_sel;
    logic [63:0]    s_di;
    logic [63:0]    s_do;

    hpdmc_fmlarb #(.sdram_depth(D)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_di(m_di),
        .m_ack(m_ack), .m_do(m_do),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
        .s_sel(s_sel), .s_di(s_di), .s_do(s_do)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] stb;
        int         exp;
    } vec_t;

    vec_t        vec[8];
    int          n_chk = 0;
    int          n_fail = 0;
    int          want[4];
    bit          drop[4];
    int          ack_delay;
    int          stb_cnt;
    bit          force_ack;
    int          cyc = 0;
    int          last_ack_cyc;
    int          gap_exp;
    bit          gap_chk;
    bit          prev_stb;
    int          q_exp[$];
    logic [63:0] wdata[4];
    int          wbeat;
    bit          wtrack;
    bit          wt_arm;

    function automatic logic [D-1:0] adr_of(int i);
        return D'(32'h0155_0000 + 32'(i) * 32'h40);
    endfunction

    function automatic logic [7:0] sel_of(int i);
        return 8'(8'hA0 + i);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < 4; i++) begin
            want[i] = 0;
            drop[i] = 1'b0;
        end
        m_stb = 4'b0000;
        m_we = 4'b0000;
        force_ack = 1'b0;
        s_ack = 1'b0;
        stb_cnt = 0;
        ack_delay = 3;
        wtrack = 1'b0;
        wt_arm = 1'b0;
        gap_chk = 1'b0;
        last_ack_cyc = -1;
        prev_stb = 1'b0;
        q_exp.delete();
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        clear_bench();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // One bus cycle: masters and controller model drive, then outputs are checked.
    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (drop[i]) begin
                m_stb[i] = 1'b0;
                drop[i] = 1'b0;
            end else if (want[i] > 0) begin
                m_stb[i] = 1'b1;
            end
        end
        if (wtrack) m_di[128 +: 64] = wdata[wbeat];
        #1;
        if (s_stb) begin
            s_ack = (stb_cnt >= ack_delay);
            stb_cnt = s_ack ? 0 : stb_cnt + 1;
        end else begin
            s_ack = 1'b0;
            stb_cnt = 0;
        end
        s_ack = s_ack | force_ack;
        s_do = {$urandom, $urandom};
        #1;
        check("m_do_bcast", m_do, s_do);
        check("m_ack_onehot", 64'($onehot0(m_ack)), 64'd1);
        if (gap_chk && s_stb && !prev_stb && last_ack_cyc >= 0)
            check("stb_gap", 64'(cyc - last_ack_cyc), 64'(gap_exp));
        if (wtrack) begin
            check("wburst_s_di", s_di, wdata[wbeat]);
            check("wburst_s_stb", 64'(s_stb), 64'd0);
            wbeat++;
            if (wbeat == 4) wtrack = 1'b0;
        end
        if (m_ack != 4'b0000) begin
            int idx;
            idx = 0;
            for (int i = 0; i < 4; i++) if (m_ack[i]) idx = i;
            if (q_exp.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ack_order: unexpected ack for m%0d, required none (cycle %0d)", idx, cyc);
            end else begin
                check("ack_order", 64'(idx), 64'(q_exp.pop_front()));
            end
            check("ack_s_adr", 64'(s_adr), 64'(adr_of(idx)));
            check("ack_s_sel", 64'(s_sel), 64'(sel_of(idx)));
            check("ack_s_we", 64'(s_we), 64'(m_we[idx]));
            drop[idx] = 1'b1;
            if (want[idx] > 0) want[idx]--;
            last_ack_cyc = cyc;
            gap_exp = m_we[idx] ? 5 : 2;
            if (wt_arm && idx == 2) begin
                check("wburst_beat0", s_di, wdata[0]);
                wbeat = 1;
                wtrack = 1'b1;
                wt_arm = 1'b0;
                want[1] = 1;
            end
        end
        prev_stb = s_stb;
    endtask

    task automatic run_until(string name, int max);
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < max) begin
            tick();
            n++;
        end
        n_chk++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d acks outstanding, required 0", name, q_exp.size());
            q_exp.delete();
        end
    endtask

    initial begin
        vec[0] = '{4'b0001, 0};
        vec[1] = '{4'b0010, 1};
        vec[2] = '{4'b0100, 2};
        vec[3] = '{4'b1000, 3};
        vec[4] = '{4'b1100, 2};
        vec[5] = '{4'b1010, 1};
        vec[6] = '{4'b0110, 1};
        vec[7] = '{4'b1111, 0};

        for (int i = 0; i < 4; i++) begin
            m_adr[i*D +: D] = adr_of(i);
            m_sel[8*i +: 8] = sel_of(i);
            m_di[64*i +: 64] = {32'hD0D0_0000 + 32'(i), 32'h1234_5678};
        end
        wdata[0] = 64'hA0A0_0000_0000_00A0;
        wdata[1] = 64'hA1A1_1111_1111_11A1;
        wdata[2] = 64'hA2A2_2222_2222_22A2;
        wdata[3] = 64'hA3A3_3333_3333_33A3;
        s_do = '0;
        sys_rst_n = 1'b0;
        clear_bench();

        // Idle after reset; stray s_ack must not produce an ack.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            force_ack = (c >= 5);
            tick();
            check("idle_s_stb", 64'(s_stb), 64'd0);
            check("idle_m_ack", 64'(m_ack), 64'd0);
        end
        force_ack = 1'b0;

        // First grant out of reset for several request patterns.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) if (vec[v].stb[i]) want[i] = 1;
            q_exp.push_back(vec[v].exp);
            run_until("vec_first_grant", 20);
        end

        // All four reading continuously.
        do_reset();
        gap_chk = 1'b1;
        want[0] = 2;
        want[1] = 1;
        want[2] = 1;
        want[3] = 1;
`ifdef HPDMC_FMLARB_FIXEDPRIO_EN
        q_exp.push_back(0); q_exp.push_back(1); q_exp.push_back(0);
        q_exp.push_back(2); q_exp.push_back(3);
`else
        q_exp.push_back(0); q_exp.push_back(1); q_exp.push_back(2);
        q_exp.push_back(3); q_exp.push_back(0);
`endif
        run_until("rr_order", 60);

        // m2 write burst; m1 arrives during the burst and must wait for it.
        do_reset();
        gap_chk = 1'b1;
        m_we[2] = 1'b1;
        m_di[128 +: 64] = wdata[0];
        wt_arm = 1'b1;
        want[2] = 1;
        q_exp.push_back(2);
        q_exp.push_back(1);
        run_until("wburst_then_m1", 40);
        m_di[128 +: 64] = {32'hD0D0_0002, 32'h1234_5678};

        // m3 withdraws before ack.
        do_reset();
        ack_delay = 1000;
        want[3] = 1;
        begin
            int n;
            n = 0;
            while (!s_stb && n < 5) begin
                tick();
                n++;
            end
        end
        check("t4_granted", 64'(s_stb), 64'd1);
        tick();
        want[3] = 0;
        drop[3] = 1'b1;
        force_ack = 1'b1;
        tick();
        check("t4_stb_drop", 64'(s_stb), 64'd0);
        check("t4_no_ack", 64'(m_ack), 64'd0);
        tick();
        check("t4_idle_stb", 64'(s_stb), 64'd0);
        check("t4_idle_ack", 64'(m_ack), 64'd0);
        force_ack = 1'b0;
        ack_delay = 3;
        want[3] = 1;
        q_exp.push_back(3);
        tick();
        check("t4_rearb_stb", 64'(s_stb), 64'd0);
        tick();
        check("t4_regrant_stb", 64'(s_stb), 64'd1);
        run_until("t4_regrant", 20);

        // Reset during write beat 2, then m3/m0 contend.
        do_reset();
        m_we[0] = 1'b1;
        want[0] = 1;
        q_exp.push_back(0);
        run_until("t5_write", 20);
        tick();
        tick();
        force_ack = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        check("t5_rst_s_stb", 64'(s_stb), 64'd0);
        check("t5_rst_m_ack", 64'(m_ack), 64'd0);
        clear_bench();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        want[0] = 1;
        want[3] = 1;
        q_exp.push_back(0);
        q_exp.push_back(3);
        run_until("t5_after_reset", 40);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
